// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared pipeline definitions for the fetch queue
package fetch_queue_pkg;
  localparam int FQ_DEPTH = 8;
  localparam logic [31:0] NOOP_INST = 32'h47ff041f;
  typedef enum logic [1:0] {
    BUSY_NONE = 2'd0,
    BUSY_ONE  = 2'd1,
    BUSY_FULL = 2'd2
  } busy_e;
  typedef struct packed {
    logic [63:0] npc;
    logic [31:0] ir;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue_mem.sv
// fq_mem: entry storage with two write ports and two combinational read ports
module fq_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we0,
  input  logic             we1,
  input  logic [PTR_W-1:0] wa0,
  input  logic [PTR_W-1:0] wa1,
  input  fq_entry_t        wd0,
  input  fq_entry_t        wd1,
  input  logic [PTR_W-1:0] ra0,
  input  logic [PTR_W-1:0] ra1,
  output fq_entry_t        rd0,
  output fq_entry_t        rd1
);
  fq_entry_t mem [DEPTH];
  always_ff @(posedge clock) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end
  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: 2-in/2-out circular instruction buffer between fetch and decode
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] if_NPC,
  input  logic [31:0] if_IR0,
  input  logic [31:0] if_IR1,
  input  logic        if_valid_inst0,
  input  logic        if_valid_inst1,
  input  logic        flush,
  input  logic [1:0]  id_take,
  output logic [1:0]  fq_busy,
  output logic [31:0] id_IR0,
  output logic [31:0] id_IR1,
  output logic [63:0] id_NPC0,
  output logic [63:0] id_NPC1,
  output logic        id_valid_inst0,
  output logic        id_valid_inst1
);
  localparam int CW = PTR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  logic [PTR_W-1:0] head, tail;
  logic [CW-1:0] count, free, n_valid, acc, take;
  fq_entry_t wd0, wd1, rd0, rd1;
  // room is judged on the registered count so it matches what fq_busy told fetch
  always_comb begin
    free = DEPTH_C - count;
    n_valid = CW'(if_valid_inst0) + CW'(if_valid_inst1);
    acc = (n_valid > free) ? free : n_valid;
    take = (CW'(id_take) > count) ? count : CW'(id_take);
    wd0 = '{npc: if_NPC, ir: if_valid_inst0 ? if_IR0 : if_IR1};
    wd1 = '{npc: if_NPC + 64'd4, ir: if_IR1};
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + PTR_W'(take);
      tail <= tail + PTR_W'(acc);
      count <= count + acc - take;
    end
  end
  fq_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clock (clock),
    .we0   (!flush && acc != '0),
    .we1   (!flush && acc == CW'(2)),
    .wa0   (tail),
    .wa1   (tail + PTR_W'(1)),
    .wd0   (wd0),
    .wd1   (wd1),
    .ra0   (head),
    .ra1   (head + PTR_W'(1)),
    .rd0   (rd0),
    .rd1   (rd1)
  );
  assign id_valid_inst0 = (count != '0) && !flush;
  assign id_valid_inst1 = (count > CW'(1)) && !flush;
  assign id_IR0 = id_valid_inst0 ? rd0.ir : NOOP_INST;
  assign id_IR1 = id_valid_inst1 ? rd1.ir : NOOP_INST;
  assign id_NPC0 = id_valid_inst0 ? rd0.npc : 64'd0;
  assign id_NPC1 = id_valid_inst1 ? rd1.npc : 64'd0;
  assign fq_busy = (free > CW'(1)) ? BUSY_NONE : (free == CW'(1)) ? BUSY_ONE : BUSY_FULL;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard queue and a negedge monitor
module tb_fetch_queue;
  localparam logic [31:0] NOOP = 32'h47ff041f;
  typedef struct packed {
    logic v0, v1;
    logic [31:0] ir0, ir1;
    logic [63:0] n0, n1;
    logic [1:0] busy;
  } exp_t;
  logic clock = 1'b0, reset;
  logic [63:0] if_NPC;
  logic [31:0] if_IR0, if_IR1;
  logic if_valid_inst0, if_valid_inst1, flush;
  logic [1:0] id_take, fq_busy;
  logic [31:0] id_IR0, id_IR1;
  logic [63:0] id_NPC0, id_NPC1;
  logic id_valid_inst0, id_valid_inst1;
  exp_t exp_q[$];
  string nm_q[$];
  int n_chk = 0, n_fail = 0;
  exp_t E;
  fetch_queue dut (
    .clock(clock), .reset(reset), .if_NPC(if_NPC), .if_IR0(if_IR0), .if_IR1(if_IR1),
    .if_valid_inst0(if_valid_inst0), .if_valid_inst1(if_valid_inst1), .flush(flush),
    .id_take(id_take), .fq_busy(fq_busy), .id_IR0(id_IR0), .id_IR1(id_IR1),
    .id_NPC0(id_NPC0), .id_NPC1(id_NPC1), .id_valid_inst0(id_valid_inst0),
    .id_valid_inst1(id_valid_inst1)
  );
  always #5 clock = ~clock;
  function automatic exp_t ex(input logic v0, v1, input logic [31:0] i0, i1,
                              input logic [63:0] n0, n1, input logic [1:0] b);
    ex = '{v0: v0, v1: v1, ir0: i0, ir1: i1, n0: n0, n1: n1, busy: b};
  endfunction
  task automatic cyc(input logic v0, v1, input logic [63:0] npc, input logic [31:0] i0, i1,
                     input logic [1:0] tk, input logic fl, input exp_t e, input string nm);
    if_valid_inst0 = v0;
    if_valid_inst1 = v1;
    if_NPC = npc;
    if_IR0 = i0;
    if_IR1 = i1;
    id_take = tk;
    flush = fl;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clock);
    #1;
  endtask
  task automatic enq(input logic v0, v1, input logic [63:0] npc, input logic [31:0] i0, i1,
                     input exp_t e, input string nm);
    cyc(v0, v1, npc, i0, i1, 2'd0, 1'b0, e, nm);
  endtask
  task automatic idle(input logic [1:0] tk, input exp_t e, input string nm);
    cyc(1'b0, 1'b0, 64'd0, 32'd0, 32'd0, tk, 1'b0, e, nm);
  endtask
  always @(negedge clock) begin
    exp_t e, g;
    string nm;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      nm = nm_q.pop_front();
      g = '{v0: id_valid_inst0, v1: id_valid_inst1, ir0: id_IR0, ir1: id_IR1,
            n0: id_NPC0, n1: id_NPC1, busy: fq_busy};
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s: got v=%b%b ir=%h/%h npc=%h/%h busy=%0d, expected v=%b%b ir=%h/%h npc=%h/%h busy=%0d",
                 nm, g.v0, g.v1, g.ir0, g.ir1, g.n0, g.n1, g.busy,
                 e.v0, e.v1, e.ir0, e.ir1, e.n0, e.n1, e.busy);
      end
    end
  end
  initial begin
    E = ex(0, 0, NOOP, NOOP, 0, 0, 0);
    reset = 1'b0;
    if_valid_inst0 = 0; if_valid_inst1 = 0; if_NPC = 0; if_IR0 = 0; if_IR1 = 0;
    id_take = 0; flush = 0;
    repeat (2) @(posedge clock);
    #1;
    idle(0, E, "rst_hold");
    reset = 1'b1;
    idle(0, E, "rst_idle");
    // single pair then drain
    enq(1, 1, 64'h104, 32'h01234567, 32'h89abcdef, E, "pair_pre");
    idle(2, ex(1, 1, 32'h01234567, 32'h89abcdef, 64'h104, 64'h108, 0), "pair");
    // fill to full; fifth pair dropped even with id_take=2
    enq(1, 1, 64'h2000, 32'ha0000000, 32'ha0000001, E, "fill0");
    enq(1, 1, 64'h2010, 32'ha0000002, 32'ha0000003, ex(1, 1, 32'ha0000000, 32'ha0000001, 64'h2000, 64'h2004, 0), "fill1");
    enq(1, 1, 64'h2020, 32'ha0000004, 32'ha0000005, ex(1, 1, 32'ha0000000, 32'ha0000001, 64'h2000, 64'h2004, 0), "fill2");
    enq(1, 1, 64'h2030, 32'ha0000006, 32'ha0000007, ex(1, 1, 32'ha0000000, 32'ha0000001, 64'h2000, 64'h2004, 0), "fill3");
    cyc(1, 1, 64'h2040, 32'ha0000008, 32'ha0000009, 2, 0, ex(1, 1, 32'ha0000000, 32'ha0000001, 64'h2000, 64'h2004, 2), "full");
    idle(2, ex(1, 1, 32'ha0000002, 32'ha0000003, 64'h2010, 64'h2014, 0), "drain1");
    idle(2, ex(1, 1, 32'ha0000004, 32'ha0000005, 64'h2020, 64'h2024, 0), "drain2");
    idle(2, ex(1, 1, 32'ha0000006, 32'ha0000007, 64'h2030, 64'h2034, 0), "drain3");
    idle(0, E, "full_drop");
    // odd fill to 7, then a pair where only inst0 fits
    enq(1, 1, 64'h3000, 32'hb0000000, 32'hb0000001, E, "odd0");
    enq(1, 1, 64'h3010, 32'hb0000002, 32'hb0000003, ex(1, 1, 32'hb0000000, 32'hb0000001, 64'h3000, 64'h3004, 0), "odd1");
    enq(1, 1, 64'h3020, 32'hb0000004, 32'hb0000005, ex(1, 1, 32'hb0000000, 32'hb0000001, 64'h3000, 64'h3004, 0), "odd2");
    enq(1, 0, 64'h3030, 32'hb0000006, 32'h0, ex(1, 1, 32'hb0000000, 32'hb0000001, 64'h3000, 64'h3004, 0), "odd3");
    enq(1, 1, 64'h3040, 32'hb0000007, 32'hb0000008, ex(1, 1, 32'hb0000000, 32'hb0000001, 64'h3000, 64'h3004, 1), "odd_busy1");
    idle(2, ex(1, 1, 32'hb0000000, 32'hb0000001, 64'h3000, 64'h3004, 2), "odd_full");
    idle(2, ex(1, 1, 32'hb0000002, 32'hb0000003, 64'h3010, 64'h3014, 0), "odd_drain1");
    idle(2, ex(1, 1, 32'hb0000004, 32'hb0000005, 64'h3020, 64'h3024, 0), "odd_drain2");
    idle(2, ex(1, 1, 32'hb0000006, 32'hb0000007, 64'h3030, 64'h3040, 0), "odd_drain3");
    idle(0, E, "odd_drop");
    // compaction of a lone inst1, then over-take and take on empty
    enq(0, 1, 64'h200, 32'h11111111, 32'hdeadbeef, E, "compact_pre");
    idle(2, ex(1, 0, 32'hdeadbeef, NOOP, 64'h200, 0, 0), "compact");
    idle(2, E, "overtake");
    idle(0, E, "empty_take");
    // pair written across the wrap point, drained with mixed takes
    enq(1, 1, 64'h4000, 32'hd0000000, 32'hd0000001, E, "wrap0");
    enq(1, 1, 64'h4010, 32'hd0000002, 32'hd0000003, ex(1, 1, 32'hd0000000, 32'hd0000001, 64'h4000, 64'h4004, 0), "wrap1");
    enq(1, 1, 64'h4020, 32'hd0000004, 32'hd0000005, ex(1, 1, 32'hd0000000, 32'hd0000001, 64'h4000, 64'h4004, 0), "wrap2");
    idle(1, ex(1, 1, 32'hd0000000, 32'hd0000001, 64'h4000, 64'h4004, 0), "take1_a");
    idle(1, ex(1, 1, 32'hd0000001, 32'hd0000002, 64'h4004, 64'h4010, 0), "take1_b");
    idle(2, ex(1, 1, 32'hd0000002, 32'hd0000003, 64'h4010, 64'h4014, 0), "take2");
    idle(2, ex(1, 1, 32'hd0000004, 32'hd0000005, 64'h4020, 64'h4024, 0), "wrap");
    idle(0, E, "wrap_empty");
    // flush with simultaneous enqueue and dequeue
    enq(1, 1, 64'h5000, 32'he0000000, 32'he0000001, E, "fl0");
    enq(1, 1, 64'h5010, 32'he0000002, 32'he0000003, ex(1, 1, 32'he0000000, 32'he0000001, 64'h5000, 64'h5004, 0), "fl1");
    enq(1, 0, 64'h5020, 32'he0000004, 32'h0, ex(1, 1, 32'he0000000, 32'he0000001, 64'h5000, 64'h5004, 0), "fl2");
    cyc(1, 1, 64'h5030, 32'he0000005, 32'he0000006, 1, 1, E, "flush_cycle");
    idle(0, E, "post_flush");
    enq(1, 1, 64'h6000, 32'hf0000000, 32'hf0000001, E, "refill0");
    enq(1, 1, 64'h6010, 32'hf0000002, 32'hf0000003, ex(1, 1, 32'hf0000000, 32'hf0000001, 64'h6000, 64'h6004, 0), "refill1");
    // asynchronous reset: checked at the negedge before any clock edge
    reset = 1'b0;
    idle(0, E, "async_rst");
    reset = 1'b1;
    idle(0, E, "after_rst");
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending checks, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
